kmp_lps_builder: RTL and testbench

Upstream companion of the KMP matcher. It loads the search pattern from the pattern ROM and computes the KMP failure function (the LPS table: longest proper prefix that is also a suffix). The matcher then reads this table on a mismatch instead of resetting its pattern counter. The block runs once per pattern load and holds the finished table, stable and readable, until the next start.

---
 rtl/kmp_lps_builder_if.sv | 29 ++
 rtl/kmp_lps_builder.sv | 105 ++++++++++
 tb/tb_kmp_lps_builder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/kmp_lps_builder_if.sv
// Handshake and table-read bundle between the LPS builder, its pattern ROM and the KMP matcher.
// The master side drives start/pat_len/pat_data/lps_addr; the builder sits on the slave side.
interface kmp_lps_builder_if #(
  parameter int PAT_MAX = 8
);
  localparam int AW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
  localparam int LW = $clog2(PAT_MAX + 1);

  logic          start;
  logic [LW-1:0] pat_len;
  logic [AW-1:0] pat_addr;
  logic [7:0]    pat_data;
  logic [AW-1:0] lps_addr;
  logic [LW-1:0] lps_data;
  logic [LW-1:0] len_q;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output start, pat_len, pat_data, lps_addr,
    input  pat_addr, lps_data, len_q, busy, done, err
  );

  modport slave (
    input  start, pat_len, pat_data, lps_addr,
    output pat_addr, lps_data, len_q, busy, done, err
  );
endinterface

// File: rtl/kmp_lps_builder.sv
// Loads a pattern from a synchronous ROM and builds the KMP failure (LPS) table,
// holding the finished table readable until the next start.
module kmp_lps_builder #(
  parameter int PAT_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  kmp_lps_builder_if.slave bus
);
  localparam int AW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
  localparam int LW = $clog2(PAT_MAX + 1);
  localparam logic [LW-1:0] MAX_LEN = LW'(PAT_MAX);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_COMPUTE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]                 state;
  logic [PAT_MAX-1:0][7:0]    pbuf;
  logic [PAT_MAX-1:0][LW-1:0] lps;
  logic [LW-1:0]              m_q, len_q, i, k, j;
  logic                       err;

  logic [LW-1:0] i_inc, k_inc;
  logic          len_ok, chr_eq;

  assign i_inc  = i + 1'b1;
  assign k_inc  = k + 1'b1;
  assign len_ok = (bus.pat_len != '0) && (bus.pat_len <= MAX_LEN);
  assign chr_eq = (pbuf[i[AW-1:0]] == pbuf[k[AW-1:0]]);

  // Address wraps modulo PAT_MAX, so m-1 for m==PAT_MAX lands on the last entry.
  assign bus.pat_addr = (state == S_LOAD) ?
                        ((j < m_q) ? j[AW-1:0] : m_q[AW-1:0] - 1'b1) : '0;
  assign bus.lps_data = lps[bus.lps_addr];
  assign bus.len_q    = len_q;
  assign bus.err      = err;
  assign bus.busy     = (state == S_LOAD) || (state == S_COMPUTE);
  assign bus.done     = (state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      pbuf  <= '0;
      lps   <= '0;
      m_q   <= '0;
      len_q <= '0;
      i     <= '0;
      k     <= '0;
      j     <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (len_ok) begin
              m_q    <= bus.pat_len;
              j      <= '0;
              i      <= LW'(1);
              k      <= '0;
              lps[0] <= '0;
              err    <= 1'b0;
              state  <= S_LOAD;
            end else begin
              err   <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_LOAD: begin
          // ROM data in this cycle belongs to the address presented one cycle earlier.
          if (j != '0) pbuf[j[AW-1:0] - 1'b1] <= bus.pat_data;
          if (j == m_q) begin
            if (m_q == LW'(1)) begin
              len_q <= m_q;
              state <= S_DONE;
            end else begin
              state <= S_COMPUTE;
            end
          end else begin
            j <= j + 1'b1;
          end
        end
        S_COMPUTE: begin
          if (chr_eq) begin
            k              <= k_inc;
            lps[i[AW-1:0]] <= k_inc;
            i              <= i_inc;
          end else if (k != '0) begin
            k <= lps[k[AW-1:0] - 1'b1];
          end else begin
            lps[i[AW-1:0]] <= '0;
            i              <= i_inc;
          end
          if ((chr_eq || k == '0) && i_inc == m_q) begin
            len_q <= m_q;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_kmp_lps_builder.sv
// Directed bench for kmp_lps_builder: expected results are queued when a build is
// launched and popped as the DUT finishes.
module tb_kmp_lps_builder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kmp_lps_builder_if #(.PAT_MAX(8)) bus ();
  kmp_lps_builder #(.PAT_MAX(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] rom [8];
  always @(posedge clk) bus.pat_data <= rom[bus.pat_addr];

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int model_tab[8];
  int model_len = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed %0d expected none", obs);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic push_reset_state(input string name);
    push({name, " busy"}, 0);
    push({name, " done"}, 0);
    push({name, " err"}, 0);
    push({name, " pat_addr"}, 0);
    push({name, " len_q"}, 0);
    push({name, " lps_data"}, 0);
  endtask

  task automatic pop_reset_state();
    pop_chk(32'(bus.busy));
    pop_chk(32'(bus.done));
    pop_chk(32'(bus.err));
    pop_chk(32'(bus.pat_addr));
    pop_chk(32'(bus.len_q));
    pop_chk(32'(bus.lps_data));
  endtask

  // One build from start to done; poke pulses an illegal start while busy.
  task automatic run(input string name, input logic [7:0] pat[8], input int m,
                     input int exp_cyc, input int e[8], input bit poke);
    bit legal;
    int cyc;
    legal = (m >= 1 && m <= 8);
    for (int n = 0; n < 8; n++) rom[n] = pat[n];
    if (legal) begin
      for (int n = 0; n < m; n++) model_tab[n] = e[n];
      model_len = m;
    end
    push({name, " busy_c1"}, 32'(legal));
    push({name, " done_cycle"}, exp_cyc);
    push({name, " err"}, 32'(!legal));
    push({name, " busy_at_done"}, 0);
    push({name, " len_q"}, model_len);
    push({name, " done_after"}, 0);
    for (int n = 0; n < 8; n++) push($sformatf("%s lps[%0d]", name, n), model_tab[n]);

    @(negedge clk);
    bus.start   = 1'b1;
    bus.pat_len = 4'(m);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    pop_chk(32'(bus.busy));
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (poke && cyc == 3) begin
        bus.start   = 1'b1;
        bus.pat_len = 4'd0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    pop_chk(cyc);
    pop_chk(32'(bus.err));
    pop_chk(32'(bus.busy));
    pop_chk(32'(bus.len_q));
    @(negedge clk);
    pop_chk(32'(bus.done));
    for (int n = 0; n < 8; n++) begin
      bus.lps_addr = 3'(n);
      #1;
      pop_chk(32'(bus.lps_data));
    end
    @(negedge clk);
  endtask

  initial begin
    int  saw_done;
    int  cyc;
    for (int n = 0; n < 8; n++) begin
      rom[n]       = 8'h00;
      model_tab[n] = 0;
    end
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.pat_len  = 4'd0;
    bus.lps_addr = 3'd0;

    push_reset_state("reset");
    repeat (2) @(negedge clk);
    pop_reset_state();
    rst = 1'b1;
    @(negedge clk);

    run("abab", '{8'h41, 8'h42, 8'h41, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 9,
        '{0, 0, 1, 2, 0, 0, 0, 0}, 1'b0);
    run("aaaa", '{8'h41, 8'h41, 8'h41, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 9,
        '{0, 1, 2, 3, 0, 0, 0, 0}, 1'b0);
    run("aabaaab", '{8'h41, 8'h41, 8'h42, 8'h41, 8'h41, 8'h41, 8'h42, 8'h00}, 7, 17,
        '{0, 1, 0, 1, 2, 2, 3, 0}, 1'b0);
    run("single", '{8'h41, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A}, 1, 3,
        '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b0);
    run("len0", '{8'h43, 8'h43, 8'h43, 8'h43, 8'h43, 8'h43, 8'h43, 8'h43}, 0, 1,
        '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b0);
    run("len9", '{8'h43, 8'h43, 8'h43, 8'h43, 8'h43, 8'h43, 8'h43, 8'h43}, 9, 1,
        '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b0);
    run("abab_again", '{8'h41, 8'h42, 8'h41, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 9,
        '{0, 0, 1, 2, 0, 0, 0, 0}, 1'b0);

    // Abort an 8-character build with reset in cycle 5.
    for (int n = 0; n < 8; n++) rom[n] = 8'h41 + 8'(n);
    bus.lps_addr = 3'd6;
    push("pre_abort lps[6]", 32'(model_tab[6]));
    #1;
    pop_chk(32'(bus.lps_data));
    push_reset_state("abort");
    push("abort no_done", 0);
    bus.start   = 1'b1;
    bus.pat_len = 4'd8;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 5) begin
      @(negedge clk);
      cyc++;
    end
    rst = 1'b0;
    #1;
    pop_reset_state();
    for (int n = 0; n < 8; n++) model_tab[n] = 0;
    model_len = 0;
    saw_done  = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done++;
    end
    pop_chk(saw_done);

    run("abab_poke", '{8'h41, 8'h42, 8'h41, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 9,
        '{0, 0, 1, 2, 0, 0, 0, 0}, 1'b1);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
